// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core priority, starvation guard for port A, core lock for AMOs.
// Grant is combinational and responses come 1 cycle after accept; a port that is not granted sees ready low and holds its request.
module dmem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            c_req_valid,
    output logic            c_req_ready,
    input  logic [XLEN-1:0] c_addr,
    input  logic [63:0]     c_wdata,
    input  logic            c_we,
    input  logic [2:0]      c_funct3,
    input  logic            c_lock,
    output logic            c_rsp_valid,
    output logic [63:0]     c_rsp_rdata,
    input  logic            a_req_valid,
    output logic            a_req_ready,
    input  logic [XLEN-1:0] a_addr,
    input  logic [63:0]     a_wdata,
    input  logic            a_we,
    input  logic [2:0]      a_funct3,
    output logic            a_rsp_valid,
    output logic [63:0]     a_rsp_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [63:0]     mem_write_data,
    output logic            mem_read,
    output logic            mem_write,
    output logic [2:0]      mem_funct3,
    input  logic [63:0]     mem_read_data,
    output logic            locked
);
    localparam int CW = 8;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          locked_q, locked_d;
    logic          pend_q, pend_d;
    logic          own_a_q, own_a_d;
    logic          load_q, load_d;
    logic          grant_c, grant_a;

    // Reset forces every handshake and strobe low, including a response already in flight.
    always_comb begin
        grant_c = 1'b0;
        grant_a = 1'b0;
        if (!reset) begin
            if (locked_q)                         grant_c = c_req_valid;
            else if (cnt_q == LIMIT && a_req_valid) grant_a = 1'b1;
            else if (c_req_valid)                 grant_c = 1'b1;
            else if (a_req_valid)                 grant_a = 1'b1;
        end
    end

    assign c_req_ready = grant_c;
    assign a_req_ready = grant_a;

    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_funct3     = '0;
        if (grant_c) begin
            mem_addr       = c_addr;
            mem_write_data = c_wdata;
            mem_read       = ~c_we;
            mem_write      = c_we;
            mem_funct3     = c_funct3;
        end else if (grant_a) begin
            mem_addr       = a_addr;
            mem_write_data = a_wdata;
            mem_read       = ~a_we;
            mem_write      = a_we;
            mem_funct3     = a_funct3;
        end
    end

    always_comb begin
        pend_d   = grant_c | grant_a;
        own_a_d  = grant_a;
        load_d   = grant_a ? ~a_we : ~c_we;
        locked_d = grant_c ? c_lock : locked_q;
        cnt_d    = '0;
        // Counting continues while locked so A wins immediately after unlock.
        if (a_req_valid && !grant_a)
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
            pend_q   <= 1'b0;
            own_a_q  <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            pend_q   <= pend_d;
            own_a_q  <= own_a_d;
            load_q   <= load_d;
        end
    end

    assign c_rsp_valid = pend_q & ~own_a_q & ~reset;
    assign a_rsp_valid = pend_q &  own_a_q & ~reset;
    assign c_rsp_rdata = (c_rsp_valid && load_q) ? mem_read_data : '0;
    assign a_rsp_rdata = (a_rsp_valid && load_q) ? mem_read_data : '0;
    assign locked      = locked_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a rule-level reference model.
module tb_dmem_arbiter;
    localparam int XLEN = 32;
    localparam int LIM  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            c_req_valid, c_req_ready, c_we, c_lock, c_rsp_valid;
    logic [XLEN-1:0] c_addr;
    logic [63:0]     c_wdata, c_rsp_rdata;
    logic [2:0]      c_funct3;
    logic            a_req_valid, a_req_ready, a_we, a_rsp_valid;
    logic [XLEN-1:0] a_addr;
    logic [63:0]     a_wdata, a_rsp_rdata;
    logic [2:0]      a_funct3;
    logic [XLEN-1:0] mem_addr;
    logic [63:0]     mem_write_data, mem_read_data;
    logic            mem_read, mem_write, locked;
    logic [2:0]      mem_funct3;

    always #5 clk = ~clk;

    dmem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_we(c_we), .c_funct3(c_funct3), .c_lock(c_lock),
        .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_we(a_we), .a_funct3(a_funct3),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_read_data(mem_read_data),
        .locked(locked)
    );

    // Environment memory: 256 doublewords, registered read, preloadable.
    logic [63:0] env_mem [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [63:0] pl_dat;
    always @(posedge clk) begin
        if (pl_en) env_mem[pl_idx] <= pl_dat;
        else if (mem_write) env_mem[mem_addr[10:3]] <= mem_write_data;
        if (mem_read) mem_read_data <= env_mem[mem_addr[10:3]];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int          m_cnt = 0;
    bit          m_locked = 0, m_pend = 0, m_own_a = 0, m_load = 0;
    logic [63:0] m_rd = '0;
    logic [63:0] ref_mem [256];
    bit          acc_c_last = 0, acc_a_last = 0;

    // Check all outputs at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        bit gc, ga, ecv, eav;
        logic [63:0] e_addr, e_wd;
        logic [2:0]  e_f3;
        bit e_rd, e_wr;
        @(negedge clk);
        gc = 0; ga = 0;
        if (!reset) begin
            if (m_locked) gc = c_req_valid;
            else if (m_cnt == LIM && a_req_valid) ga = 1;
            else if (c_req_valid) gc = 1;
            else if (a_req_valid) ga = 1;
        end
        e_addr = '0; e_wd = '0; e_f3 = '0; e_rd = 0; e_wr = 0;
        if (gc) begin e_addr = 64'(c_addr); e_wd = c_wdata; e_f3 = c_funct3; e_rd = !c_we; e_wr = c_we; end
        if (ga) begin e_addr = 64'(a_addr); e_wd = a_wdata; e_f3 = a_funct3; e_rd = !a_we; e_wr = a_we; end
        ecv = m_pend && !m_own_a && !reset;
        eav = m_pend &&  m_own_a && !reset;
        chk("c_ready", 64'(c_req_ready), 64'(gc));
        chk("a_ready", 64'(a_req_ready), 64'(ga));
        chk("mem_read", 64'(mem_read), 64'(e_rd));
        chk("mem_write", 64'(mem_write), 64'(e_wr));
        chk("mem_addr", 64'(mem_addr), e_addr);
        chk("mem_wdata", mem_write_data, e_wd);
        chk("mem_funct3", 64'(mem_funct3), 64'(e_f3));
        chk("c_rsp_valid", 64'(c_rsp_valid), 64'(ecv));
        chk("a_rsp_valid", 64'(a_rsp_valid), 64'(eav));
        chk("c_rsp_rdata", c_rsp_rdata, (ecv && m_load) ? m_rd : 64'd0);
        chk("a_rsp_rdata", a_rsp_rdata, (eav && m_load) ? m_rd : 64'd0);
        if (!reset) chk("locked", 64'(locked), 64'(m_locked));
        if (reset) begin
            m_cnt = 0; m_locked = 0; m_pend = 0;
        end else begin
            m_pend = gc || ga;
            m_own_a = ga;
            if (gc || ga) begin
                int idx;
                idx = int'(e_addr[10:3]);
                if (e_wr) begin ref_mem[idx] = e_wd; m_load = 0; end
                else begin m_rd = ref_mem[idx]; m_load = 1; end
            end
            if (gc) m_locked = c_lock;
            if (a_req_valid && !ga) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
            else m_cnt = 0;
        end
        acc_c_last = gc;
        acc_a_last = ga;
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input bit v, input logic [31:0] ad, input bit we, input logic [63:0] wd, input bit lk);
        c_req_valid = v; c_addr = ad; c_we = we; c_wdata = wd; c_lock = lk; c_funct3 = 3'b011;
    endtask

    task automatic set_a(input bit v, input logic [31:0] ad, input bit we, input logic [63:0] wd);
        a_req_valid = v; a_addr = ad; a_we = we; a_wdata = wd; a_funct3 = 3'b011;
    endtask

    // New random request only when the port is idle or its last request was taken.
    task automatic rnd_drive(input int pc, input int pa);
        if (!c_req_valid || acc_c_last) begin
            c_req_valid = ($urandom_range(0, 99) < pc);
            c_addr = 32'($urandom_range(0, 255)) << 3;
            c_wdata = {$urandom, $urandom};
            c_we = 1'($urandom);
            c_funct3 = 3'($urandom);
            c_lock = ($urandom_range(0, 3) == 0);
        end
        if (!a_req_valid || acc_a_last) begin
            a_req_valid = ($urandom_range(0, 99) < pa);
            a_addr = 32'($urandom_range(0, 255)) << 3;
            a_wdata = {$urandom, $urandom};
            a_we = 1'($urandom);
            a_funct3 = 3'($urandom);
        end
    endtask

    initial begin
        logic [9:0]  pat;
        logic [63:0] v;
        reset = 1'b1;
        set_c(0, 0, 0, 0, 0);
        set_a(0, 0, 0, 0);
        pl_en = 1'b1; pl_idx = '0; pl_dat = '0;
        for (int i = 0; i < 256; i++) begin
            v = (i == 8'h20) ? 64'h11223344 : {$urandom, $urandom};
            ref_mem[i] = v;
            pl_idx = 8'(i); pl_dat = v;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #3 chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_c_rsp", 64'(c_rsp_valid), 64'd0);
        tick();

        // Core load with port A idle
        set_c(1, 32'h100, 0, 0, 0);
        #3 chk("t1_ready", 64'(c_req_ready), 64'd1);
        chk("t1_mem_read", 64'(mem_read), 64'd1);
        tick();
        c_req_valid = 1'b0;
        #3 chk("t1_rsp_valid", 64'(c_rsp_valid), 64'd1);
        chk("t1_rdata", c_rsp_rdata, 64'h11223344);
        chk("t1_a_rsp", 64'(a_rsp_valid), 64'd0);
        tick();

        // Both ports continuously valid: A wins at cycles 4 and 9
        set_c(1, 32'h40, 0, 0, 0);
        set_a(1, 32'h48, 0, 0);
        for (int i = 0; i < 10; i++) begin
            #3 pat[i] = a_req_ready;
            tick();
        end
        chk("starve_pattern", 64'(pat), 64'(10'b1000010000));
        set_c(0, 0, 0, 0, 0);
        set_a(0, 0, 0, 0);
        tick();

        // Lock window: A valid throughout, never granted until unlock
        set_a(1, 32'h58, 0, 0);
        set_c(1, 32'h300, 1, 64'hCAFE_F00D_1234_5678, 1);
        #3 chk("lk_c_ready", 64'(c_req_ready), 64'd1);
        tick();
        c_req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #3 chk("lk_locked", 64'(locked), 64'd1);
            chk("lk_a_blocked", 64'(a_req_ready), 64'd0);
            tick();
        end
        set_c(1, 32'h300, 0, 0, 0);
        #3 chk("lk_unlock_accept", 64'(c_req_ready), 64'd1);
        tick();
        c_req_valid = 1'b0;
        #3 chk("lk_unlocked", 64'(locked), 64'd0);
        chk("lk_a_wins", 64'(a_req_ready), 64'd1);
        chk("lk_rdata", c_rsp_rdata, 64'hCAFE_F00D_1234_5678);
        tick();
        a_req_valid = 1'b0;
        tick();

        // Back-to-back A store then load
        set_a(1, 32'h200, 1, 64'hDEADBEEF);
        tick();
        set_a(1, 32'h200, 0, 0);
        #3 chk("bb_store_rsp", 64'(a_rsp_valid), 64'd1);
        chk("bb_store_rdata", a_rsp_rdata, 64'd0);
        tick();
        a_req_valid = 1'b0;
        #3 chk("bb_load_rsp", 64'(a_rsp_valid), 64'd1);
        chk("bb_load_rdata", a_rsp_rdata, 64'hDEADBEEF);
        tick();

        // Reset right after a core load accept drops the response
        set_c(1, 32'h100, 0, 0, 1);
        tick();
        c_req_valid = 1'b0;
        reset = 1'b1;
        #3 chk("rr_no_rsp", 64'(c_rsp_valid), 64'd0);
        tick();
        reset = 1'b0;
        #3 chk("rr_locked", 64'(locked), 64'd0);
        chk("rr_no_rsp2", 64'(c_rsp_valid), 64'd0);
        tick();

        // Idle
        for (int i = 0; i < 5; i++) begin
            #3 chk("idle_strobes", 64'({mem_read, mem_write, c_req_ready, a_req_ready}), 64'd0);
            tick();
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rnd_drive(20 + (i / 300) * 8, 30 + ((i / 200) % 5) * 15);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port C (core MEM stage) and port A (auxiliary master, e.g. DMA or debug).
- Selects one request per cycle and drives the memory's address/data/control combinationally.
- Tracks the memory's 1-cycle registered read latency and routes each response to the requester that issued it.
- Provides core priority, a starvation guard for port A, and a core lock for atomic read-modify-write sequences.

Parameters:
XLEN, 32, address width (32 or 64)
STARVE_LIMIT, 4, consecutive lost cycles after which port A wins once (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
c_req_valid  in  1  core request valid
c_req_ready  out  1  core request accepted this cycle
c_addr  in  XLEN  core byte address
c_wdata  in  64  core write data
c_we  in  1  1=store, 0=load
c_funct3  in  3  size/sign encoding
c_lock  in  1  hold memory for core after this access (AMO)
c_rsp_valid  out  1  core response (1 cycle after accept)
c_rsp_rdata  out  64  core load data
a_req_valid, a_req_ready, a_addr, a_wdata, a_we, a_funct3  same as core, port A
a_rsp_valid  out  1  port A response
a_rsp_rdata  out  64  port A load data
mem_addr  out  XLEN  to memory
mem_write_data  out  64  to memory
mem_read  out  1  to memory
mem_write  out  1  to memory
mem_funct3  out  3  to memory
mem_read_data  in  64  registered memory output
locked  out  1  lock state (debug visibility)

Behaviour:
- Reset (synchronous): `locked`=0, starvation count=0, response-pending=0. All rsp_valid=0, all ready=0, mem_read=mem_write=0.
- Grant decision is combinational, computed in the following priority order:
  1. `locked`=1: only C may be granted; A is never granted.
  2. Else if count==STARVE_LIMIT and a_req_valid: grant A.
  3. Else if c_req_valid: grant C.
  4. Else if a_req_valid: grant A.
  5. Else: no grant.
- Ready/acceptance:
  - x_req_ready = grant to x. It may depend on x_req_valid, and is 0 when x_req_valid=0.
  - Acceptance = valid & ready. At most one port is accepted per cycle.
  - Requesters hold their request stable until accepted.
- Memory drive:
  - On acceptance, mem_* come from the granted port: mem_read=~we, mem_write=we.
  - Without acceptance: mem_read=mem_write=0; mem_addr, mem_write_data and mem_funct3 = 0.
- Response:
  - Registers owner port and type at acceptance.
  - The next cycle pulses x_rsp_valid=1 for exactly one cycle, for loads and stores alike (store = write acknowledge).
  - x_rsp_rdata = mem_read_data when x_rsp_valid and the access was a load; 0 otherwise.
  - Latency: accept at cycle N -> response at N+1. Back-to-back accepts give back-to-back responses with no bubble.
- Starvation counter:
  - Increments each cycle a_req_valid=1 and A is not accepted.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 when A is accepted or a_req_valid=0.
  - While `locked`, it still counts and saturates; A wins on the first cycle after unlock if still requesting.
- Lock:
  - Core accept with c_lock=1 sets `locked` next cycle.
  - Core accept with c_lock=0 clears it.
  - c_lock is ignored without a core accept.
  - A core request without acceptance never changes `locked`.
- Simultaneous events:
  - Both ports valid, count<STARVE_LIMIT, unlocked: C wins, count increments.
  - Count reaches limit while a C request is pending: A wins, C waits.
- Reset asserted during a pending response: the response is dropped; no rsp_valid in the following cycle.
- No address checking or misalignment handling; addresses pass through unchanged.

Test Plan:
- C load of addr 0x100 (memory pre-loaded 0x11223344) while A idle -> c_req_ready=1 in cycle N, mem_read=1; c_rsp_valid=1 in N+1 with rdata 0x...11223344; a_rsp_valid stays 0.
- C and A continuously valid, STARVE_LIMIT=4 -> C granted cycles 0-3, A granted cycle 4, count resets, C granted cycles 5-8, A granted cycle 9.
- C store with c_lock=1 then load with c_lock=0, A valid throughout -> `locked`=1 between the two C accepts. A is never granted in that window, and is granted in the first cycle after unlock (count saturated at 4).
- Back-to-back A store 0xDEADBEEF to 0x200 then A load of 0x200 -> responses in consecutive cycles; second returns 0xDEADBEEF; first (store) rdata=0.
- Reset asserted the cycle after a C load accept -> no c_rsp_valid, `locked`=0, count=0.
- Both ports idle -> mem_read=mem_write=0 and both ready=0 every cycle.
